spi_adc_cfg_responder: RTL and testbench

- SPI target (slave) side of the ADC 3-wire-plus-CSB configuration protocol: 24-bit frame, {addr[7:0], data[15:0]}, MSB first; addr[7]=1 write, addr[7]=0 read.
- Oversamples SCLK/CSB/MOSI in the fabric clock domain, decodes frames into a local 16-bit register file and returns read data on MISO.
- Used as an ADC configuration-port model for loopback self-test of the FPGA-side SPI master, and as a slave config port for board-level controllers.

---
 rtl/spi_adc_cfg_responder_if.sv | 44 ++++
 rtl/spi_adc_cfg_responder.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_spi_adc_cfg_responder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_cfg_responder_if.sv
// -----------------------------------------------------------------------------
// spi_adc_cfg_responder_if
//
// Pin-level bundle of the 3-wire-plus-CSB ADC configuration port.
//
// Signals:
//   spi_sclk_i   SPI clock, driven by the master (idle low, mode 0)
//   spi_csb_i    chip select, active low, driven by the master
//   spi_mosi_i   master-out data, changed by the master while SCLK is low
//   spi_miso_o   slave-out data, changed by the target after SCLK falls
//   spi_miso_oe  drive enable for spi_miso_o
//
// Modports:
//   master  the FPGA-side SPI master or a bench driver
//   slave   the configuration responder
//
// Frame semantics: a frame spans one CSB low period. The master changes MOSI
// while SCLK is low and samples MISO on the SCLK rising edge. The target
// samples MOSI on the rising edge and updates MISO after the falling edge.
// There is no back-pressure: the master never waits for the target.
// -----------------------------------------------------------------------------
interface spi_adc_cfg_responder_if;
    logic spi_sclk_i;
    logic spi_csb_i;
    logic spi_mosi_i;
    logic spi_miso_o;
    logic spi_miso_oe;

    modport master (
        output spi_sclk_i,
        output spi_csb_i,
        output spi_mosi_i,
        input  spi_miso_o,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sclk_i,
        input  spi_csb_i,
        input  spi_mosi_i,
        output spi_miso_o,
        output spi_miso_oe
    );
endinterface

// File: rtl/spi_adc_cfg_responder.sv
// -----------------------------------------------------------------------------
// spi_adc_cfg_responder
//
// SPI target side of the ADC configuration protocol. Frames are 24 bits,
// {addr[7:0], data[15:0]}, MSB first; addr[7]=1 is a write, addr[7]=0 a read.
// SCLK, CSB and MOSI are oversampled in the clk domain (clk >= 4x SCLK), frames
// are decoded into a local register file, and read data is returned on MISO.
//
// Parameters:
//   NUM_REGS     number of 16-bit registers, index = addr[6:0] (1..128)
//   SYNC_STAGES  synchroniser depth on the SPI inputs (>= 2)
//   REG_RESET    reset value of every register
//
// Ports:
//   clk          fabric clock
//   reset        asynchronous, active-high reset
//   spi          SPI pins (slave modport of spi_adc_cfg_responder_if)
//   cfg_wr_stb   one-clk pulse per committed write
//   cfg_wr_addr  register index of the last committed write
//   cfg_wr_data  data of the last committed write
//   cfg_rd_addr  fabric-side register index
//   cfg_rd_data  combinational register read at cfg_rd_addr (0 if out of range)
//   frame_err    one-clk pulse on a malformed frame (bit count != 24)
//   busy         a frame is in progress and has been accepted
//   dbg_state    current FSM state (encoding of state_t)
//
// Optional feature, macro SPI_CFG_RESP_STATUS_REG_EN:
//   defined   -> index NUM_REGS-1 is read-only and returns
//                {err_cnt[7:0], ok_cnt[7:0]}, saturating counts of frame_err
//                pulses and of 24-bit frames; writes to it are dropped silently.
//   undefined -> index NUM_REGS-1 is an ordinary register, no counters.
//
// Timing: CSB rise at the pin to cfg_wr_stb / frame_err is SYNC_STAGES+2 clk
// (SYNC_STAGES sync flops, one edge-detect delay, one commit stage).
// -----------------------------------------------------------------------------
module spi_adc_cfg_responder #(
    parameter int          NUM_REGS    = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] REG_RESET   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_adc_cfg_responder_if.slave spi,
    output logic                  cfg_wr_stb,
    output logic [6:0]            cfg_wr_addr,
    output logic [15:0]           cfg_wr_data,
    input  logic [6:0]            cfg_rd_addr,
    output logic [15:0]           cfg_rd_data,
    output logic                  frame_err,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ADDR      = 2'd2,
        DATA      = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // -------------------------------------------------------------------------
    // Stage 0 takes the pin; stage SYNC_STAGES-1 is the synchronised value.
    // The CSB chain resets to 0 ("selected") so that a frame already running
    // when reset releases keeps the FSM in WAIT_IDLE until CSB really goes high.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   csb_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            csb_sync  <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk_i};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0],  spi.spi_csb_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            csb_d     <= csb_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, csb_s, mosi_s;
    logic sclk_rise, sclk_fall, csb_fall, csb_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign csb_rise  =  csb_s  & ~csb_d;
    assign csb_fall  = ~csb_s  &  csb_d;

    // -------------------------------------------------------------------------
    // Register file and optional status counters
    // -------------------------------------------------------------------------
    logic [15:0] regs [NUM_REGS];

`ifdef SPI_CFG_RESP_STATUS_REG_EN
    logic [7:0] err_cnt;
    logic [7:0] ok_cnt;
`endif

    // Register read as seen by both the SPI read path and the fabric port.
    function automatic logic [15:0] reg_lookup(input logic [6:0] idx);
        logic [15:0] val;
        val = 16'h0000;
        if ({25'd0, idx} < NUM_REGS) begin
            val = regs[idx[IDX_W-1:0]];
        end
`ifdef SPI_CFG_RESP_STATUS_REG_EN
        if ({25'd0, idx} == NUM_REGS - 1) begin
            val = {err_cnt, ok_cnt};
        end
`endif
        return val;
    endfunction

    // True for indices that a write frame may update.
    function automatic logic idx_writable(input logic [6:0] idx);
        logic ok;
        ok = ({25'd0, idx} < NUM_REGS);
`ifdef SPI_CFG_RESP_STATUS_REG_EN
        if ({25'd0, idx} == NUM_REGS - 1) begin
            ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    assign cfg_rd_data = reg_lookup(cfg_rd_addr);

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    state_t      state;
    logic [4:0]  bit_cnt;
    logic [7:0]  addr_sr;
    logic [7:0]  addr_q;
    logic [15:0] data_sr;
    logic [15:0] shadow;
    logic        miso_q;
    logic        miso_oe_q;
    logic        busy_q;

    // Commit stage: decided on csb_rise, acted on one clk later.
    logic        commit_wr;
    logic        commit_err;
    logic [6:0]  commit_idx;
    logic [15:0] commit_data;
`ifdef SPI_CFG_RESP_STATUS_REG_EN
    logic        commit_ok;
`endif

    logic [7:0]  addr_next;
    assign addr_next = {addr_sr[6:0], mosi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_IDLE;
            bit_cnt     <= 5'd0;
            addr_sr     <= 8'h00;
            addr_q      <= 8'h00;
            data_sr     <= 16'h0000;
            shadow      <= 16'h0000;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            commit_wr   <= 1'b0;
            commit_err  <= 1'b0;
            commit_idx  <= 7'd0;
            commit_data <= 16'h0000;
`ifdef SPI_CFG_RESP_STATUS_REG_EN
            commit_ok   <= 1'b0;
`endif
        end else begin
            commit_wr  <= 1'b0;
            commit_err <= 1'b0;
`ifdef SPI_CFG_RESP_STATUS_REG_EN
            commit_ok  <= 1'b0;
`endif
            case (state)
                WAIT_IDLE: begin
                    if (csb_s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (csb_fall) begin
                        bit_cnt <= 5'd0;
                        addr_sr <= 8'h00;
                        data_sr <= 16'h0000;
                        busy_q  <= 1'b1;
                        state   <= ADDR;
                    end
                end

                ADDR, DATA: begin
                    if (csb_rise) begin
                        // End of frame: release MISO now, commit next clk.
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        miso_oe_q   <= 1'b0;
                        miso_q      <= 1'b0;
                        commit_idx  <= addr_q[6:0];
                        commit_data <= data_sr;
                        // A frame ending in ADDR has bit_cnt < 8, so it lands
                        // in the error branch regardless of the stale addr_q.
                        if (bit_cnt == 5'd24) begin
                            commit_wr <= addr_q[7] & idx_writable(addr_q[6:0]);
`ifdef SPI_CFG_RESP_STATUS_REG_EN
                            commit_ok <= 1'b1;
`endif
                        end else begin
                            commit_err <= 1'b1;
                        end
                    end else if (state == ADDR) begin
                        if (sclk_rise) begin
                            addr_sr <= addr_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                addr_q <= addr_next;
                                state  <= DATA;
                                if (!addr_next[7]) begin
                                    shadow <= reg_lookup(addr_next[6:0]);
                                end
                            end
                        end
                    end else begin
                        // DATA: the counter keeps running on reads too so that
                        // short or long read frames are flagged as well.
                        if (sclk_rise) begin
                            if (bit_cnt != 5'd31) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                            if (addr_q[7]) begin
                                data_sr <= {data_sr[14:0], mosi_s};
                            end
                        end
                        if (sclk_fall && !addr_q[7]) begin
                            miso_oe_q <= 1'b1;
                            miso_q    <= shadow[15];
                            shadow    <= {shadow[14:0], 1'b0};
                        end
                    end
                end

                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign spi.spi_miso_o  = miso_q;
    assign spi.spi_miso_oe = miso_oe_q;
    assign busy            = busy_q;
    assign dbg_state       = state;

    // -------------------------------------------------------------------------
    // Commit: register update, write strobe and error pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_RESET;
            end
            cfg_wr_stb  <= 1'b0;
            cfg_wr_addr <= 7'd0;
            cfg_wr_data <= 16'h0000;
            frame_err   <= 1'b0;
        end else begin
            cfg_wr_stb <= commit_wr;
            frame_err  <= commit_err;
            if (commit_wr) begin
                regs[commit_idx[IDX_W-1:0]] <= commit_data;
                cfg_wr_addr                 <= commit_idx;
                cfg_wr_data                 <= commit_data;
            end
        end
    end

`ifdef SPI_CFG_RESP_STATUS_REG_EN
    // Saturating frame statistics, updated in step with the commit outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= 8'h00;
            ok_cnt  <= 8'h00;
        end else begin
            if (commit_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (commit_ok && ok_cnt != 8'hFF) begin
                ok_cnt <= ok_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_adc_cfg_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_adc_cfg_responder
//
// 100 MHz fabric clock, 10 MHz SCLK (5 clk per half period). A frame driver
// plays the SPI master; a reference model of the register file predicts the
// commit outcome of every frame (what gets written, whether it is an error)
// and the cycle it must appear on, SYNC_STAGES+2 clk after CSB rises at the
// pin. One compare process checks the fabric-side outputs every cycle.
// -----------------------------------------------------------------------------
module tb_spi_adc_cfg_responder;

  localparam int NUM_REGS    = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  cfg_rd_addr;
  logic        cfg_wr_stb;
  logic [6:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic [15:0] cfg_rd_data;
  logic        frame_err;
  logic        busy;
  logic [1:0]  dbg_state;

  spi_adc_cfg_responder_if spi_bus ();

  spi_adc_cfg_responder #(
    .NUM_REGS    (NUM_REGS),
    .SYNC_STAGES (SYNC_STAGES),
    .REG_RESET   (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi_bus.slave),
    .cfg_wr_stb  (cfg_wr_stb),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rd_data (cfg_rd_data),
    .frame_err   (frame_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard state
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  logic [15:0] m_regs [NUM_REGS];
  logic [6:0]  m_last_addr;
  logic [15:0] m_last_data;
  int          m_ok;
  int          m_err;

  // Expected commit of the frame in flight.
  int          exp_due = -1;
  logic        exp_wr, exp_errf, exp_okf;
  logic [6:0]  exp_addr;
  logic [15:0] exp_data;

  // Observed events, for the literal per-scenario checks.
  int          stb_seen = 0;
  int          err_seen = 0;
  logic [6:0]  seen_addr;
  logic [15:0] seen_data;

  logic        rd_fixed_en = 1'b0;
  logic [6:0]  rd_fixed    = 7'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [6:0] a);
`ifdef SPI_CFG_RESP_STATUS_REG_EN
    if (a == 7'(NUM_REGS - 1)) return {8'(m_err), 8'(m_ok)};
`endif
    if (a < 7'(NUM_REGS)) return m_regs[a[3:0]];
    return 16'h0000;
  endfunction

  function automatic logic m_writable(input logic [6:0] a);
`ifdef SPI_CFG_RESP_STATUS_REG_EN
    if (a == 7'(NUM_REGS - 1)) return 1'b0;
`endif
    return a < 7'(NUM_REGS);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0000;
    m_last_addr = 7'd0;
    m_last_data = 16'h0000;
    m_ok        = 0;
    m_err       = 0;
    exp_due     = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle, away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic due;
    due = (cyc == exp_due);
    if (due && exp_wr) begin
      m_regs[exp_addr[3:0]] = exp_data;
      m_last_addr = exp_addr;
      m_last_data = exp_data;
    end
    if (due && exp_okf && m_ok < 255) m_ok++;
    if (due && exp_errf && m_err < 255) m_err++;
    check("wr_stb", cfg_wr_stb, due && exp_wr);
    check("frame_err", frame_err, due && exp_errf);
    check("wr_addr", cfg_wr_addr, m_last_addr);
    check("wr_data", cfg_wr_data, m_last_data);
    check("rd_data", cfg_rd_data, m_read(cfg_rd_addr));
    if (cfg_wr_stb === 1'b1) begin
      stb_seen++;
      seen_addr = cfg_wr_addr;
      seen_data = cfg_wr_data;
    end
    if (frame_err === 1'b1) err_seen++;
  end

  // Fabric-side read address wanders between edges unless pinned.
  initial begin
    cfg_rd_addr = 7'd0;
    forever begin
      @(posedge clk);
      #2;
      cfg_rd_addr = rd_fixed_en ? rd_fixed : 7'($urandom_range(0, 20));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One SPI frame of nbits SCLK pulses. rst_after >= 0 pulses reset right
  // after that (0-based) rising edge. Returns the 16 bits read on MISO.
  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input int nbits,
                            input int rst_after, output logic [15:0] rd);
    logic [23:0] fr;
    logic        accepted;
    logic        is_read;
    logic [15:0] exp_rd;
    fr       = {a, d};
    rd       = 16'h0000;
    accepted = 1'b1;
    is_read  = ~a[7];
    exp_rd   = m_read(a[6:0]);
    spi_bus.spi_csb_i = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bus.spi_mosi_i = (i < 24) ? fr[23 - i] : 1'($urandom_range(0, 1));
      wait_clk(HALF);
      if (i < 8) begin
        check("miso_oe_addr", spi_bus.spi_miso_oe, 1'b0);
      end else if (i < 24) begin
        check("miso_oe_data", spi_bus.spi_miso_oe, accepted && is_read);
        if (accepted && is_read) rd[23 - i] = spi_bus.spi_miso_o;
      end
      spi_bus.spi_sclk_i = 1'b1;
      if (i == rst_after) begin
        pulse_reset();
        accepted = 1'b0;
      end
      wait_clk(HALF);
      spi_bus.spi_sclk_i = 1'b0;
    end
    wait_clk(3);
    check("busy_in_frame", busy, accepted);
    spi_bus.spi_csb_i = 1'b1;
    if (accepted) begin
      exp_okf  = (nbits == 24);
      exp_errf = (nbits != 24);
      exp_wr   = a[7] && (nbits == 24) && m_writable(a[6:0]);
      exp_addr = a[6:0];
      exp_data = d;
      exp_due  = cyc + SYNC_STAGES + 2;
    end
    wait_clk(12);
    check("busy_after", busy, 1'b0);
    check("miso_oe_after", spi_bus.spi_miso_oe, 1'b0);
    check("miso_after", spi_bus.spi_miso_o, 1'b0);
    if (accepted && is_read && nbits >= 24) check("spi_rd", rd, exp_rd);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] rd;
    int s0, e0;
    logic [7:0]  ra;
    logic [15:0] rdat;
    int          rn;

    reset = 1'b1;
    spi_bus.spi_csb_i  = 1'b1;
    spi_bus.spi_sclk_i = 1'b0;
    spi_bus.spi_mosi_i = 1'b0;
    model_clear();
    wait_clk(3);
    check("rst_busy", busy, 1'b0);
    check("rst_miso", spi_bus.spi_miso_o, 1'b0);
    check("rst_miso_oe", spi_bus.spi_miso_oe, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clk(6);

    // Write 0x81,0xABCD then read it back over SPI.
    s0 = stb_seen; e0 = err_seen;
    send_frame(8'h81, 16'hABCD, 24, -1, rd);
    check("w1_stb_count", stb_seen - s0, 1);
    check("w1_err_count", err_seen - e0, 0);
    check("w1_addr", seen_addr, 7'd1);
    check("w1_data", seen_data, 16'hABCD);
    s0 = stb_seen;
    send_frame(8'h01, 16'h0000, 24, -1, rd);
    check("r1_data", rd, 16'hABCD);
    check("r1_stb_count", stb_seen - s0, 0);

    // Short write: 20 SCLK edges.
    s0 = stb_seen; e0 = err_seen;
    send_frame(8'h82, 16'h7777, 20, -1, rd);
    check("short_err_count", err_seen - e0, 1);
    check("short_stb_count", stb_seen - s0, 0);
    send_frame(8'h02, 16'h0000, 24, -1, rd);
    check("short_reg2", rd, 16'h0000);

    // Out-of-range index: silent on write, zero on read.
    s0 = stb_seen; e0 = err_seen;
    send_frame(8'h9F, 16'h1234, 24, -1, rd);
    send_frame(8'h1F, 16'h0000, 24, -1, rd);
    check("oor_rd", rd, 16'h0000);
    check("oor_stb_count", stb_seen - s0, 0);
    check("oor_err_count", err_seen - e0, 0);

    // Reset after the 12th SCLK of a write; the rest of the frame is ignored.
    s0 = stb_seen; e0 = err_seen;
    send_frame(8'h83, 16'h5555, 24, 11, rd);
    check("rstmid_stb_count", stb_seen - s0, 0);
    check("rstmid_err_count", err_seen - e0, 0);
    send_frame(8'h03, 16'h0000, 24, -1, rd);
    check("rstmid_reg3", rd, 16'h0000);
    s0 = stb_seen;
    send_frame(8'h83, 16'h5555, 24, -1, rd);
    check("rstmid_retry_stb", stb_seen - s0, 1);
    send_frame(8'h03, 16'h0000, 24, -1, rd);
    check("rstmid_retry_rd", rd, 16'h5555);

`ifdef SPI_CFG_RESP_STATUS_REG_EN
    // Status register: 3 good frames, 1 short, then the read itself.
    pulse_reset();
    wait_clk(6);
    send_frame(8'h84, 16'h0004, 24, -1, rd);
    send_frame(8'h85, 16'h0005, 24, -1, rd);
    send_frame(8'h86, 16'h0006, 24, -1, rd);
    send_frame(8'h87, 16'h0007, 13, -1, rd);
    send_frame(8'h0F, 16'h0000, 24, -1, rd);
    rd_fixed_en = 1'b1;
    rd_fixed    = 7'h0F;
    wait_clk(2);
    check("status_reg", cfg_rd_data, 16'h0104);
    rd_fixed_en = 1'b0;
`else
    send_frame(8'h8F, 16'hBEEF, 24, -1, rd);
    send_frame(8'h0F, 16'h0000, 24, -1, rd);
    check("reg15_rw", rd, 16'hBEEF);
`endif

    // Randomised frames against the model.
    for (int k = 0; k < 30; k++) begin
      ra   = {1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 17))};
      rdat = 16'($urandom);
      rn   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : 24;
      send_frame(ra, rdat, rn, -1, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
